// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem word index and
// registers the returned instruction into IF/ID under an IDLE/RUN/HALT FSM.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 32,
  parameter int          ADDR_W     = 5,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] read_adr,
  input  logic [31:0] instruction,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        halted,
  output logic        fault
);

  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_RUN      = 2'd1;
  localparam logic [1:0]  ST_HALT     = 2'd2;
  localparam logic [31:0] LIMIT_BYTES = 32'(IMEM_DEPTH) << 2;

  // A fetchable address is word aligned and below the end of instruction memory.
  function automatic logic pc_in_range(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr < LIMIT_BYTES);
  endfunction

  logic [1:0]  state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic        valid_r, valid_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] ifpc_r, ifpc_s;
  logic        halted_r, halted_s;
  logic        fault_r, fault_s;

  assign read_adr    = {{(32-ADDR_W){1'b0}}, pc_r[ADDR_W+1:2]};
  assign if_id_valid = valid_r;
  assign if_id_instr = instr_r;
  assign if_id_pc    = ifpc_r;
  assign halted      = halted_r;
  assign fault       = fault_r;

  // Next-state logic: run-control FSM with redirect > stall > range > halt > issue priority.
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    valid_s  = valid_r;
    instr_s  = instr_r;
    ifpc_s   = ifpc_r;
    halted_s = halted_r;
    fault_s  = fault_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          valid_s = 1'b0;
          if (pc_in_range(redirect_pc)) begin
            pc_s = redirect_pc;
          end else begin
            fault_s  = 1'b1;
            halted_s = 1'b1;
            state_s  = ST_HALT;
          end
        end else if (stall) begin
          pc_s = pc_r;
        end else if (!pc_in_range(pc_r)) begin
          fault_s  = 1'b1;
          halted_s = 1'b1;
          valid_s  = 1'b0;
          state_s  = ST_HALT;
        end else if (instruction == HALT_INSTR) begin
          // The halt word is never issued; pc keeps pointing at it.
          halted_s = 1'b1;
          valid_s  = 1'b0;
          state_s  = ST_HALT;
        end else begin
          instr_s = instruction;
          ifpc_s  = pc_r;
          valid_s = 1'b1;
          pc_s    = pc_r + 32'd4;
        end
      end
      ST_HALT: begin
        valid_s = 1'b0;
        if (start) begin
          pc_s     = RESET_PC;
          fault_s  = 1'b0;
          halted_s = 1'b0;
          state_s  = ST_RUN;
        end else begin
          halted_s = 1'b1;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        valid_s  = 1'b0;
        halted_s = 1'b0;
      end
    endcase
  end

  // State and pipeline registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      pc_r     <= RESET_PC;
      valid_r  <= 1'b0;
      instr_r  <= 32'd0;
      ifpc_r   <= 32'd0;
      halted_r <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      valid_r  <= valid_s;
      instr_r  <= instr_s;
      ifpc_r   <= ifpc_s;
      halted_r <= halted_s;
      fault_r  <= fault_s;
    end
  end

endmodule
